// File: rtl/traffic_light_sequencer_pkg.sv
// Shared lane and phase definitions for the traffic light sequencer and its lane picker.
package traffic_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_ALL_RED = 2'd3
  } phase_e;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] idx);
    logic [NUM_LANES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/traffic_light_sequencer_rr_lane_picker.sv
// Round-robin lane picker: first requesting lane after cur, or cur+1 when nobody else requests.
module rr_lane_picker
  import traffic_pkg::*;
(
  input  logic [LANE_W-1:0]    cur,
  input  logic [NUM_LANES-1:0] req,
  output logic [LANE_W-1:0]    nxt
);

  logic [LANE_W-1:0] cand;

  // Scan farthest candidate first so the nearest requesting lane is the last, winning, write.
  always_comb begin
    nxt  = cur + LANE_W'(1);
    cand = '0;
    for (int i = NUM_LANES - 1; i >= 1; i--) begin
      cand = cur + LANE_W'(i);
      if (req[cand]) begin
        nxt = cand;
      end
    end
  end

endmodule

// File: rtl/traffic_light_sequencer.sv
// Timed GREEN -> YELLOW -> ALL_RED sequencer per lane with round-robin lane selection
// and green extension while no other lane has demand.
module traffic_light_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_LANES-1:0] car_waiting,
  output logic [LANE_W-1:0]    traffic_light,
  output logic [1:0]           phase,
  output logic                 light_valid,
  output logic                 lane_switch
);

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYC - 1);

  phase_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              switch_q, switch_d;
  logic [LANE_W-1:0] next_lane;
  logic              others_waiting;
  logic              timer_done;

  rr_lane_picker u_picker (
    .cur (lane_q),
    .req (car_waiting),
    .nxt (next_lane)
  );

  assign others_waiting = |(car_waiting & ~lane_onehot(lane_q));
  assign timer_done     = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= PH_IDLE;
      timer_q  <= '0;
      lane_q   <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      lane_q   <= lane_d;
      switch_q <= switch_d;
    end
  end

  // Every exit taken at timer==0 reloads the timer, so it can never wrap below zero.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    lane_d   = lane_q;
    switch_d = 1'b0;
    unique case (state_q)
      PH_IDLE: begin
        if (enable) begin
          state_d = PH_GREEN;
          timer_d = GREEN_LOAD;
        end
      end
      PH_GREEN: begin
        if (!enable) begin
          state_d = PH_YELLOW;
          timer_d = YELLOW_LOAD;
        end else if (timer_done) begin
          if (others_waiting) begin
            state_d = PH_YELLOW;
            timer_d = YELLOW_LOAD;
          end else begin
            timer_d = GREEN_LOAD;
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      PH_YELLOW: begin
        if (timer_done) begin
          state_d = PH_ALL_RED;
          timer_d = ALLRED_LOAD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      PH_ALL_RED: begin
        if (timer_done) begin
          if (enable) begin
            state_d  = PH_GREEN;
            timer_d  = GREEN_LOAD;
            lane_d   = next_lane;
            switch_d = (next_lane != lane_q);
          end else begin
            state_d = PH_IDLE;
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = PH_IDLE;
      end
    endcase
  end

  always_comb begin
    phase         = state_q;
    traffic_light = lane_q;
    lane_switch   = switch_q;
    light_valid   = (state_q == PH_GREEN) || (state_q == PH_YELLOW);
  end

endmodule
